// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester round-robin arbiter in front of a registered-read BRAM
module bram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_we,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    input  logic [2*DW-1:0] req_mask,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic [AW-1:0]   ram_raddr,
    output logic            ram_re,
    output logic            ram_rclke,
    output logic [AW-1:0]   ram_waddr,
    output logic [DW-1:0]   ram_wdata,
    output logic [DW-1:0]   ram_mask,
    output logic            ram_we,
    output logic            ram_wclke,
    input  logic [DW-1:0]   ram_rdata
);
    logic          ptr_q, ptr_d;
    logic [1:0]    fire;
    logic          gnt_id;
    logic [AW-1:0] sel_addr;
    logic          re_q, re_d, we_q, we_d;
    logic [AW-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d, mask_q, mask_d;
    logic          t1_v_q, t1_v_d, t1_id_q, t1_id_d;
    logic          t2_v_q, t2_v_d, t2_id_q, t2_id_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        req_ready   = !rst_n ? 2'b00 : &req_valid ? (ptr_q ? 2'b10 : 2'b01) : req_valid;
        fire        = req_valid & req_ready;
        gnt_id      = fire[1];
        sel_addr    = gnt_id ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        ptr_d       = |fire ? ~gnt_id : ptr_q;
        re_d        = |fire & ~req_we[gnt_id];
        we_d        = |fire & req_we[gnt_id];
        raddr_d     = re_d ? sel_addr : raddr_q;
        waddr_d     = we_d ? sel_addr : waddr_q;
        wdata_d     = we_d ? (gnt_id ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0]) : wdata_q;
        mask_d      = we_d ? (gnt_id ? req_mask[2*DW-1:DW] : req_mask[DW-1:0]) : mask_q;
        // tag stages line up with ram_re and ram_rdata respectively
        t1_v_d      = re_d;
        t1_id_d     = gnt_id;
        t2_v_d      = t1_v_q;
        t2_id_d     = t1_id_q;
        rsp_valid_d = {t2_v_q & t2_id_q, t2_v_q & ~t2_id_q};
        rsp_rdata_d = t2_v_q ? ram_rdata : rsp_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= 1'b0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            t1_v_q      <= 1'b0;
            t1_id_q     <= 1'b0;
            t2_v_q      <= 1'b0;
            t2_id_q     <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            re_q        <= re_d;
            we_q        <= we_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            t1_v_q      <= t1_v_d;
            t1_id_q     <= t1_id_d;
            t2_v_q      <= t2_v_d;
            t2_id_q     <= t2_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ram_re    = re_q;
    assign ram_rclke = re_q;
    assign ram_raddr = raddr_q;
    assign ram_we    = we_q;
    assign ram_wclke = we_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign ram_mask  = mask_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed and random traffic with a queue scoreboard and a BRAM model
module tb_bram_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata, req_mask;
    logic [DW-1:0]   rsp_rdata, ram_wdata, ram_mask, ram_rdata;
    logic [AW-1:0]   ram_raddr, ram_waddr;
    logic            ram_re, ram_rclke, ram_we, ram_wclke;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            e;
    int              grants[$];
    logic [17:0]     rsp_log[$];
    logic [DW-1:0]   mem [256] = '{default: '0};
    logic [DW-1:0]   ref_mem [256] = '{default: '0};
    int              checks = 0;
    int              failures = 0;
    int              cyc = 0;
    int              nrsp = 0;
    int              g0, n0;

    bram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rclke(ram_rclke),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_mask(ram_mask),
        .ram_we(ram_we), .ram_wclke(ram_wclke), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // registered-read RAM; mask bit 1 keeps the stored bit
    always @(posedge clk) begin
        if (ram_re && ram_rclke) ram_rdata <= mem[ram_raddr];
        if (ram_we && ram_wclke) mem[ram_waddr] <= (mem[ram_waddr] & ram_mask) | (ram_wdata & ~ram_mask);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready_onehot", 64'(req_ready == 2'b11), 64'd0);
            check("rsp_onehot", 64'(rsp_valid == 2'b11), 64'd0);
            if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL rsp_missing: got none expected id %0h data %0h at cycle %0d", exp_q[0].id, exp_q[0].d, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (rsp_valid != 2'b00) begin
                nrsp++;
                rsp_log.push_back({rsp_valid, rsp_rdata});
                if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 64'(rsp_valid), 64'(e.id));
                    check("rsp_data", 64'(rsp_rdata), 64'(e.d));
                    check("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    // sample the handshake mid-cycle, update the reference and expectation queue
    task automatic cycle();
        logic [AW-1:0] a;
        logic [DW-1:0] w, m;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                a = req_addr[i*AW +: AW];
                w = req_wdata[i*DW +: DW];
                m = req_mask[i*DW +: DW];
                grants.push_back(i);
                if (req_we[i]) ref_mem[a] = (ref_mem[a] & m) | (w & ~m);
                else exp_q.push_back('{id: 2'(1 << i), d: ref_mem[a], due: cyc + 3});
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] w, input logic [DW-1:0] m);
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = w;
        req_mask[i*DW +: DW] = m;
    endtask

    task automatic op(input int i, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] w, input logic [DW-1:0] m);
        req_valid = 2'b00;
        set_req(i, we, a, w, m);
        cycle();
        req_valid = 2'b00;
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        req_valid = 2'b11;
        req_we = 2'b00;
        req_addr = '0;
        req_wdata = '0;
        req_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_strobes", 64'({ram_re, ram_rclke, ram_we, ram_wclke}), 64'd0);
        check("rst_rsp", 64'(rsp_valid), 64'd0);
        check("rst_fields", {ram_raddr, ram_waddr, ram_wdata, ram_mask}, 64'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_strobes", 64'({ram_re, ram_we, rsp_valid}), 64'd0);

        // write then read back, strobe and field timing
        set_req(0, 1'b1, 8'h05, 16'hBEEF, 16'h0000);
        cycle();
        check("single_grant", 64'(grants.size()), 64'd1);
        check("wr_strobe", 64'({ram_we, ram_wclke, ram_re}), 64'b110);
        check("wr_fields", 64'({ram_waddr, ram_wdata, ram_mask}), 64'({8'h05, 16'hBEEF, 16'h0000}));
        set_req(0, 1'b0, 8'h05, 16'h0000, 16'h0000);
        cycle();
        check("rd_strobe", 64'({ram_we, ram_re, ram_rclke}), 64'b011);
        check("rd_addr", 64'(ram_raddr), 64'h05);
        check("wr_hold", 64'({ram_waddr, ram_wdata}), 64'({8'h05, 16'hBEEF}));
        idle(4);
        check("idle_strobes", 64'({ram_re, ram_we}), 64'd0);
        check("rd_beef", 64'(rsp_log[$]), 64'({2'b01, 16'hBEEF}));

        // alternating grants under contention
        op(0, 1'b1, 8'h10, 16'h1111, 16'h0000);
        op(1, 1'b1, 8'h20, 16'h2222, 16'h0000);
        do_reset();
        g0 = grants.size();
        n0 = rsp_log.size();
        set_req(0, 1'b0, 8'h10, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 8'h20, 16'h0000, 16'h0000);
        repeat (4) cycle();
        idle(5);
        for (int k = 0; k < 4; k++) begin
            check("grant_alt", 64'(grants[g0 + k]), 64'(k % 2));
            check("rsp_alt", 64'(rsp_log[n0 + k]), (k % 2 == 0) ? 64'({2'b01, 16'h1111}) : 64'({2'b10, 16'h2222}));
        end

        // partial write: high byte masked off
        op(0, 1'b1, 8'h30, 16'hABCD, 16'h0000);
        op(1, 1'b1, 8'h30, 16'h1234, 16'hFF00);
        check("mask_out", 64'(ram_mask), 64'hFF00);
        op(0, 1'b0, 8'h30, 16'h0000, 16'h0000);
        idle(5);
        check("mask_rd", 64'(rsp_log[$]), 64'({2'b01, 16'hAB34}));

        // top address, read right after write
        op(1, 1'b1, 8'hFF, 16'h0001, 16'h0000);
        op(0, 1'b0, 8'hFF, 16'h0000, 16'h0000);
        idle(5);
        check("raw_top", 64'(rsp_log[$]), 64'({2'b01, 16'h0001}));

        // reset with reads in flight; pointer left at 1 beforehand
        op(1, 1'b0, 8'h20, 16'h0000, 16'h0000);
        op(0, 1'b0, 8'h10, 16'h0000, 16'h0000);
        n0 = nrsp;
        do_reset();
        check("post_rst2_strobes", 64'({ram_re, ram_we, rsp_valid}), 64'd0);
        idle(6);
        check("flushed_rsp", 64'(nrsp), 64'(n0));
        set_req(0, 1'b0, 8'h10, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 8'h20, 16'h0000, 16'h0000);
        g0 = grants.size();
        cycle();
        check("ptr_reset", 64'(grants[g0]), 64'd0);
        idle(5);

        // random concurrent traffic on a small address window
        for (int k = 0; k < 300; k++) begin
            req_valid = 2'($urandom);
            req_we = 2'($urandom);
            req_addr = {5'b0, 3'($urandom), 5'b0, 3'($urandom)};
            req_wdata = $urandom;
            req_mask = $urandom;
            cycle();
        end
        idle(6);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
